noc_inject_arbiter: RTL
=======================

// Module: noc_inject_arbiter
// PURPOSE
//   Shares one router injection port between N_REQ core-side requesters.
//   Each requester offers a 32-bit word (valid/ready). The block picks one by round-robin
//   and serializes it into 4 router flits, MSB byte first. Packets are atomic: no interleaving.
//   Sits between the core adapters and the router input, beside the receive-side reassembly.
// PARAMETERS
//   N_REQ    4   number of requesters, 2..16
//   SRC_W    4   width of source-id field in flit (fixed by flit format)
// PORTS
//   clk        in   1          clock, all logic on posedge
//   rst        in   1          asynchronous, active-low reset
//   req_valid  in   N_REQ      requester i has a word pending
//   req_data   in   32*N_REQ   word of requester i at [32*i+31:32*i]
//   req_ready  out  N_REQ      one-hot: word of requester i accepted this cycle
//   r_name     in   4          local router id, inserted into every flit
//   to_r       out  17         flit to router; 0 = no flit
//   r_ready    in   1          router accepts the flit currently on to_r
//   busy       out  1          packet in flight (state SEND)
//   grant_id   out  4          source index of packet in flight (0 when idle)
// BEHAVIOUR
//   - Flit format: [16]=1 valid, [15:12]=src id (zero-extended), [11:8]=r_name, [7:0]=byte.
//   - Byte order: flit0=data[31:24], flit1=[23:16], flit2=[15:8], flit3=[7:0].
//   - Reset (rst=0, async): to_r=0, busy=0, grant_id=0, req_ready=0, state=IDLE, flit_cnt=0.
//     rr_ptr=N_REQ-1, so requester 0 has top priority first. A packet in flight is dropped.
//   - FSM IDLE:
//     - req_ready[g]=1 combinationally for g = first valid index after rr_ptr (wrapping).
//     - No valid requester -> req_ready=0.
//     - On accept: latch data, g, r_name; rr_ptr<=g; go SEND; flit_cnt<=0; load flit0 into to_r.
//   - FSM SEND: to_r holds its flit until r_ready=1.
//     - r_ready=1 with flit_cnt<3: load the next flit, flit_cnt++.
//     - r_ready=1 with flit_cnt==3: to_r<=0, go IDLE.
//     - req_ready=0 throughout SEND.
//   - Latency: word accepted at edge T -> flit0 on to_r after T. With r_ready held high,
//     flits appear in 4 consecutive cycles.
//   - Throughput: IDLE lasts >=1 cycle between packets, i.e. 5 cycles per word at full rate.
//   - r_name is sampled at accept; changes mid-packet do not affect flits in flight.
//   - Data value 0 is legal and is sent; flit[16] marks validity.
//   - req_valid dropping mid-packet has no effect. The latched word is always completed.
//   - Requester asserting valid while another packet is in flight: waits; fairness via rr_ptr.
//   - All outputs except req_ready are registered.
// STRUCTURE
//   - noc_pkg holds FLIT_W=17, BYTES_PER_WORD=4, the field offsets
//     (VALID_B, SRC_LSB, RNAME_LSB, BYTE_LSB) and function make_flit(src, rname, byte).
//     The receive-side reassembly block shares the same package.
//   - Sub-module rr_arbiter #(N_REQ):
//     - inputs: req vector, ptr
//     - outputs: one-hot grant, grant index, any
//     - purely combinational; pointer register lives here in the top.
//   - Top contains the FSM, data/src latch, flit counter and output register.
// TESTING
//   1. Single word:
//      - stimulus: r_name=4'h3, req0 data=32'hA1B2C3D4, r_ready=1.
//      - response: to_r = 17'h103A1, 17'h103B2, 17'h103C3, 17'h103D4 in 4 consecutive
//        cycles, then 0; req_ready[0] pulsed once.
//   2. Round robin:
//      - stimulus: req0..3 all valid continuously.
//      - response: grant order 0,1,2,3,0; src field in flits matches; no flit interleaving.
//   3. Backpressure:
//      - stimulus: r_ready low 3 cycles during flit1.
//      - response: flit1 held stable on to_r; all 4 flits are delivered, with none
//        duplicated or skipped.
//   4. Zero data and idle:
//      - stimulus: req2 data=0.
//      - response: 4 flits 17'h12300..12300 (r_name=3); with no requests, to_r=0 and busy=0.
//   5. Mid-packet reset:
//      - stimulus: assert rst after flit1.
//      - response: to_r=0 immediately (async); after release, requester 0 is served first
//        and no leftover flits appear.
//   6. r_name change mid-packet:
//      - stimulus: change r_name after flit0.
//      - response: remaining flits keep the old r_name; the next packet uses the new one.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared flit-format definitions for the NoC injection and reassembly paths.
package noc_pkg;

  localparam int unsigned FLIT_W         = 17;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned SRC_W          = 4;
  localparam int unsigned RNAME_W        = 4;

  localparam int unsigned VALID_B   = 16;
  localparam int unsigned SRC_LSB   = 12;
  localparam int unsigned RNAME_LSB = 8;
  localparam int unsigned BYTE_LSB  = 0;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {
    IDLE,
    SEND
  } inj_state_t;

  // Assemble one flit; a valid flit always has the valid bit set, even for a zero byte.
  function automatic flit_t make_flit(input logic [SRC_W-1:0]   src,
                                      input logic [RNAME_W-1:0] rname,
                                      input logic [7:0]         byte_val);
    flit_t f;
    f                        = '0;
    f[VALID_B]               = 1'b1;
    f[SRC_LSB +: SRC_W]      = src;
    f[RNAME_LSB +: RNAME_W]  = rname;
    f[BYTE_LSB +: 8]         = byte_val;
    return f;
  endfunction

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// Requester-side handshake and router-side flit port of the injection arbiter.
interface noc_inject_arbiter_if
  import noc_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) ();

  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic [RNAME_W-1:0]  r_name;
  flit_t               to_r;
  logic                r_ready;
  logic                busy;
  logic [SRC_W-1:0]    grant_id;

  modport master (
    output req_valid, req_data, r_name, r_ready,
    input  req_ready, to_r, busy, grant_id
  );

  modport slave (
    input  req_valid, req_data, r_name, r_ready,
    output req_ready, to_r, busy, grant_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     any
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  // Scan N_REQ positions starting just after the pointer; the first hit wins.
  always_comb begin
    int unsigned      cand;
    logic [IDX_W-1:0] c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    c     = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = (32'(ptr) + i) % N_REQ;
      c    = IDX_W'(cand);
      if (!any && req[c]) begin
        any      = 1'b1;
        idx      = c;
        grant[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Round-robin injection arbiter: accepts one 32-bit word at a time and
// serialises it into four router flits, MSB byte first, without interleaving.
module noc_inject_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input logic                 clk,
  input logic                 rst,
  noc_inject_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

  inj_state_t         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        data_q, data_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [RNAME_W-1:0] rname_q, rname_d;
  flit_t              to_r_q, to_r_d;
  logic               busy_q, busy_d;

  logic [N_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [N_REQ-1:0]   req_ready_c;
  logic [31:0]        sel_word;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign sel_word = bus.req_data[32*arb_idx +: 32];

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Datapath and registered outputs; an in-flight packet is dropped on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= IDX_W'(N_REQ - 1);
      cnt_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
      rname_q <= '0;
      to_r_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      src_q   <= src_d;
      rname_q <= rname_d;
      to_r_q  <= to_r_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, accept handshake and next flit selection.
  // The latched word is shifted left per flit so the current byte is always [31:24].
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    src_d       = src_q;
    rname_d     = rname_q;
    to_r_d      = to_r_q;
    busy_d      = busy_q;
    req_ready_c = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_any && rst) begin
          req_ready_c = arb_grant;
          data_d      = sel_word;
          src_d       = SRC_W'(arb_idx);
          rname_d     = bus.r_name;
          ptr_d       = arb_idx;
          cnt_d       = '0;
          busy_d      = 1'b1;
          to_r_d      = make_flit(SRC_W'(arb_idx), bus.r_name, sel_word[31:24]);
          state_d     = SEND;
        end
      end
      SEND: begin
        if (bus.r_ready) begin
          if (cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
            to_r_d  = '0;
            busy_d  = 1'b0;
            src_d   = '0;
            state_d = IDLE;
          end else begin
            data_d = data_q << 8;
            to_r_d = make_flit(src_q, rname_q, data_q[23:16]);
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = req_ready_c;
  assign bus.to_r      = to_r_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = src_q;

endmodule
